// File: rtl/anf_fl_tex_texel_fetch.sv
// Texel fetch: wraps (u, v) into a power-of-two texture, issues in-order word reads
// under a credit limit and buffers the returned texels behind a valid/ready output.
module anf_fl_tex_texel_fetch #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_u,
  input  logic [15:0]       in_v,
  input  logic [3:0]        in_width_exp,
  input  logic [3:0]        in_height_exp,
  input  logic [ADDR_W-1:0] in_base,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_texel
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic              readyEn;
  logic              stageValid;
  logic [ADDR_W-1:0] stageAddr;
  logic [ADDR_W-1:0] nextAddr;
  logic [CW-1:0]     credits;
  logic [CW-1:0]     fifoCount;
  logic [PW-1:0]     wrPtr;
  logic [PW-1:0]     rdPtr;
  logic [31:0]       fifoMem [0:DEPTH-1];

  logic inFire;
  logic reqFire;
  logic outFire;

  logic [15:0]       uMask;
  logic [15:0]       vMask;
  logic [ADDR_W-1:0] uExt;
  logic [ADDR_W-1:0] vExt;
  logic [ADDR_W-1:0] texelIdx;

  // Repeat-wrap both indices, then form the row-major word address modulo 2^ADDR_W.
  always_comb begin
    uMask    = (16'd1 << in_width_exp) - 16'd1;
    vMask    = (16'd1 << in_height_exp) - 16'd1;
    uExt     = ADDR_W'(in_u & uMask);
    vExt     = ADDR_W'(in_v & vMask);
    texelIdx = (vExt << in_width_exp) + uExt;
    nextAddr = in_base + (texelIdx << 2);
  end

  assign mem_req_valid = stageValid && (credits != '0);
  assign mem_req_addr  = stageAddr;
  assign reqFire       = mem_req_valid && mem_req_ready;
  assign in_ready      = readyEn && (!stageValid || reqFire);
  assign inFire        = in_valid && in_ready;
  assign out_valid     = (fifoCount != '0);
  assign outFire       = out_valid && out_ready;
  assign out_texel     = fifoMem[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readyEn    <= 1'b0;
      stageValid <= 1'b0;
      stageAddr  <= '0;
    end else begin
      readyEn <= 1'b1;
      if (inFire) begin
        stageValid <= 1'b1;
        stageAddr  <= nextAddr;
      end else if (reqFire) begin
        stageValid <= 1'b0;
      end
    end
  end

  // A credit covers a request from issue until its texel leaves the output buffer,
  // which bounds the FIFO occupancy to DEPTH without any backpressure on responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CW'(DEPTH);
    end else begin
      case ({reqFire, outFire})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifoMem[i] <= '0;
      end
    end else begin
      if (mem_rsp_valid) begin
        fifoMem[wrPtr] <= mem_rsp_data;
        wrPtr          <= wrPtr + PW'(1);
      end
      if (outFire) begin
        rdPtr <= rdPtr + PW'(1);
      end
      case ({mem_rsp_valid, outFire})
        2'b10:   fifoCount <= fifoCount + CW'(1);
        2'b01:   fifoCount <= fifoCount - CW'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

endmodule

// File: tb/tb_anf_fl_tex_texel_fetch.sv
// Scoreboard bench for anf_fl_tex_texel_fetch: directed vectors, a simple in-order
// memory model and a negedge monitor that checks addresses, texels and handshakes.
module tb_anf_fl_tex_texel_fetch;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam logic [31:0] KEY = 32'hDEADAE63;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_u;
  logic [15:0]       in_v;
  logic [3:0]        in_width_exp;
  logic [3:0]        in_height_exp;
  logic [ADDR_W-1:0] in_base;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_texel;

  anf_fl_tex_texel_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_u(in_u), .in_v(in_v),
    .in_width_exp(in_width_exp), .in_height_exp(in_height_exp),
    .in_base(in_base),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_texel(out_texel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] u;
    logic [15:0] v;
    logic [3:0]  we;
    logic [3:0]  he;
    logic [31:0] base;
    logic [31:0] addr;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  vec_t        vecs [12];
  logic [31:0] expAddrQ [$];
  logic [31:0] expTexQ [$];
  pend_t       pendQ [$];
  logic [31:0] curAddr;

  int checks = 0;
  int failures = 0;
  int rspDelay = 1;
  int cyc = 0;
  int reqCount = 0;
  bit armed = 1'b0;

  int   stageOcc = 0;
  int   credM = DEPTH;
  int   bufM = 0;
  int   outstanding = 0;
  logic stallPrev = 1'b0;
  logic [31:0] addrPrev = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Memory model and monitor share one process so the response driven for the
  // coming edge is the value the handshake bookkeeping sees.
  always @(negedge clk) begin
    pend_t p;
    logic inF, rqF, ouF, rsF;
    if (!rst_n) begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      pendQ.delete();
      stageOcc    = 0;
      credM       = DEPTH;
      bufM        = 0;
      outstanding = 0;
      stallPrev   = 1'b0;
    end else begin
      cyc++;
      if (pendQ.size() > 0 && pendQ[0].due <= cyc) begin
        p = pendQ.pop_front();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = p.data;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
      inF = in_valid && in_ready;
      rqF = mem_req_valid && mem_req_ready;
      ouF = out_valid && out_ready;
      rsF = mem_rsp_valid;
      if (armed) begin
        check1("mem_req_valid", mem_req_valid, (stageOcc != 0) && (credM != 0));
        check1("in_ready", in_ready, (stageOcc == 0) || rqF);
        check1("out_valid", out_valid, bufM != 0);
      end
      if (stallPrev) begin
        check1("stall_valid_hold", mem_req_valid, 1'b1);
        check32("stall_addr_hold", mem_req_addr, addrPrev);
      end
      stallPrev = mem_req_valid && !mem_req_ready;
      addrPrev  = mem_req_addr;
      if (inF) begin
        expAddrQ.push_back(curAddr);
        expTexQ.push_back(curAddr ^ KEY);
      end
      if (rqF) begin
        reqCount++;
        if (expAddrQ.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_request actual=0x%08h required=none", mem_req_addr);
        end else begin
          check32("req_addr", mem_req_addr, expAddrQ.pop_front());
        end
        pendQ.push_back('{cyc + rspDelay, mem_req_addr ^ KEY});
      end
      if (rsF && outstanding == 0) begin
        failures++;
        $display("FAIL rsp_without_request actual=1 required=0");
      end
      if (ouF) begin
        if (expTexQ.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_texel actual=0x%08h required=none", out_texel);
        end else begin
          check32("texel", out_texel, expTexQ.pop_front());
        end
      end
      stageOcc    += int'(inF) - int'(rqF);
      credM       += int'(ouF) - int'(rqF);
      bufM        += int'(rsF) - int'(ouF);
      outstanding += int'(rqF) - int'(rsF);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyVec(input int i);
    in_valid      = 1'b1;
    in_u          = vecs[i].u;
    in_v          = vecs[i].v;
    in_width_exp  = vecs[i].we;
    in_height_exp = vecs[i].he;
    in_base       = vecs[i].base;
    curAddr       = vecs[i].addr;
  endtask

  task automatic waitFire(output int w);
    bit fired;
    fired = 1'b0;
    w = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        fired = 1'b1;
        break;
      end
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!fired) begin
      checks++; failures++;
      $display("FAIL input_accept_timeout actual=0 required=1");
    end
  endtask

  task automatic send(input int i, output int w);
    applyVec(i);
    waitFire(w);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (expTexQ.size() == 0 && pendQ.size() == 0 && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=0", expTexQ.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutTexel(input string name, input logic [31:0] exp);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=0 required=1", name);
    end else begin
      check32(name, out_texel, exp);
    end
  endtask

  initial begin
    int w;
    int r0;
    //                u        v        we    he    base           expected addr
    vecs[0]  = '{16'h0003, 16'h0002, 4'd4,  4'd4,  32'h0000_1000, 32'h0000_108C};
    vecs[1]  = '{16'hFFFF, 16'h0005, 4'd3,  4'd2,  32'h0000_0000, 32'h0000_003C};
    vecs[2]  = '{16'h0000, 16'h0000, 4'd2,  4'd2,  32'h0000_4000, 32'h0000_4000};
    vecs[3]  = '{16'h0003, 16'h0003, 4'd2,  4'd2,  32'h0000_4000, 32'h0000_403C};
    vecs[4]  = '{16'h0004, 16'h0005, 4'd2,  4'd2,  32'h0000_4000, 32'h0000_4010};
    vecs[5]  = '{16'h01FF, 16'h0102, 4'd8,  4'd8,  32'h8000_0000, 32'h8000_0BFC};
    vecs[6]  = '{16'h1234, 16'hABCD, 4'd0,  4'd0,  32'hFFFF_FFF0, 32'hFFFF_FFF0};
    vecs[7]  = '{16'h000F, 16'h0000, 4'd4,  4'd4,  32'hFFFF_FFF0, 32'h0000_002C};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 4'd15, 4'd15, 32'h0000_0000, 32'hFFFF_FFFC};
    vecs[9]  = '{16'h0400, 16'h0041, 4'd10, 4'd6,  32'h0001_0000, 32'h0001_1000};
    vecs[10] = '{16'h0001, 16'h0007, 4'd1,  4'd3,  32'h0000_0100, 32'h0000_013C};
    vecs[11] = '{16'h0123, 16'h0456, 4'd12, 4'd12, 32'h0ABC_0000, 32'h0BD1_848C};

    rst_n = 1'b0;
    in_valid = 1'b0; in_u = '0; in_v = '0; in_width_exp = '0; in_height_exp = '0;
    in_base = '0; curAddr = '0;
    mem_req_ready = 1'b1;
    out_ready = 1'b1;
    tick(3);
    check1("reset_mem_req_valid", mem_req_valid, 1'b0);
    check32("reset_mem_req_addr", mem_req_addr, 32'h0);
    check1("reset_out_valid", out_valid, 1'b0);
    check32("reset_out_texel", out_texel, 32'h0);
    rst_n = 1'b1;
    tick(1);
    armed = 1'b1;
    check1("in_ready_after_reset", in_ready, 1'b1);

    // Single fetch
    rspDelay = 1;
    send(0, w);
    check1("single_req_valid_n1", mem_req_valid, 1'b1);
    check32("single_req_addr_n1", mem_req_addr, 32'h0000_108C);
    waitOutTexel("single_texel", 32'hDEADBEEF);
    drain();

    // Index wrap
    send(1, w);
    check32("wrap_addr", mem_req_addr, 32'h0000_003C);
    drain();

    // Back-to-back streaming, texel visible three cycles after its request
    rspDelay = 2;
    r0 = reqCount;
    for (int i = 2; i < 10; i++) begin
      send(i, w);
      checkInt("stream_in_ready_wait", w, 0);
    end
    drain();
    checkInt("stream_req_count", reqCount - r0, 8);

    // Credit stall
    rspDelay = 1;
    out_ready = 1'b0;
    r0 = reqCount;
    send(10, w); send(11, w); send(0, w); send(1, w); send(2, w);
    tick(6);
    checkInt("stall_req_count", reqCount - r0, 4);
    check1("stall_in_ready", in_ready, 1'b0);
    check1("stall_mem_req_valid", mem_req_valid, 1'b0);
    check32("stall_addr", mem_req_addr, 32'h0000_4000);
    out_ready = 1'b1;
    send(3, w);
    drain();
    checkInt("stall_resume_req_count", reqCount - r0, 6);

    // Memory backpressure
    mem_req_ready = 1'b0;
    r0 = reqCount;
    send(4, w);
    applyVec(5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check1("bp_in_ready", in_ready, 1'b0);
      check32("bp_addr", mem_req_addr, 32'h0000_4010);
    end
    @(posedge clk);
    #1;
    mem_req_ready = 1'b1;
    waitFire(w);
    drain();
    checkInt("bp_req_count", reqCount - r0, 2);

    // Reset with two requests outstanding and one texel buffered
    out_ready = 1'b0;
    rspDelay = 1;
    send(6, w);
    tick(3);
    rspDelay = 30;
    send(7, w);
    send(8, w);
    tick(3);
    check1("pre_reset_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    armed = 1'b0;
    expAddrQ.delete();
    expTexQ.delete();
    #1;
    check1("midreset_mem_req_valid", mem_req_valid, 1'b0);
    check32("midreset_mem_req_addr", mem_req_addr, 32'h0);
    check1("midreset_out_valid", out_valid, 1'b0);
    check32("midreset_out_texel", out_texel, 32'h0);
    tick(2);
    rst_n = 1'b1;
    rspDelay = 1;
    tick(1);
    armed = 1'b1;
    check1("in_ready_after_midreset", in_ready, 1'b1);

    // Full credit budget restored after reset
    r0 = reqCount;
    send(9, w); send(10, w); send(11, w); send(2, w); send(3, w);
    tick(6);
    checkInt("postreset_credit_req_count", reqCount - r0, DEPTH);
    drain();

    send(0, w);
    check32("postreset_single_addr", mem_req_addr, 32'h0000_108C);
    waitOutTexel("postreset_single_texel", 32'hDEADBEEF);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anf_fl_tex_texel_fetch.md
Name: anf_fl_tex_texel_fetch

Overview:
- Consumer end of the texture coordinate denormalization stage.
- Takes the integer (u, v) texel indices produced by the denormalizer and computes the texel word address within a power-of-two texture.
- Issues in-order read requests to the texture memory port and returns the fetched 32-bit texels through a buffered valid/ready output.
- Sits between the coordinate denormalizers and the filtering/shading datapath.

Parameters:
- DEPTH, 4, maximum number of requests in flight plus responses buffered; also the response FIFO depth (power of two, 2..16).
- ADDR_W, 32, memory byte address width.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_u  input  16  u texel index from the denormalizer.
- in_v  input  16  v texel index from the denormalizer.
- in_width_exp  input  4  log2 texture width.
- in_height_exp  input  4  log2 texture height.
- in_base  input  ADDR_W  texture base byte address, word aligned.
- mem_req_valid  output  1  memory read request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  ADDR_W  byte address, bits [1:0] always 0.
- mem_rsp_valid  input  1  read data valid; in order; no backpressure.
- mem_rsp_data  input  32  texel data.
- out_valid  output  1  texel valid.
- out_ready  input  1  downstream accepts texel.
- out_texel  output  32  fetched texel.

Behaviour:
- Reset (asynchronous, rst_n low) clears all state:
  - mem_req_valid=0, mem_req_addr=0, out_valid=0, out_texel=0.
  - Address stage empty, FIFO empty, credits=DEPTH.
  - in_ready=1 one cycle after reset deasserts.
- Reset mid-operation discards the staged request, the FIFO contents and the credit state. The memory subsystem is reset together, so no stale responses arrive.
- Index wrap:
  - u_w = in_u & ((1<<in_width_exp)-1).
  - v_w = in_v & ((1<<in_height_exp)-1).
  - Indices are repeat-wrapped, never clamped.
- Address: mem_req_addr = in_base + (((v_w << in_width_exp) + u_w) << 2).
  - Computed in ADDR_W bits; overflow wraps modulo 2^ADDR_W.
  - The computed address is registered into the address stage on the input handshake.
- Address stage (one entry):
  - in_ready = !stage_valid || (mem_req_valid && mem_req_ready).
  - A new input may load in the same cycle the current entry issues (back-to-back, one request per cycle).
- Credit counter, range 0..DEPTH:
  - mem_req_valid = stage_valid && (credits != 0).
  - Decrement on mem request handshake; increment on output handshake.
  - Both in the same cycle: unchanged.
  - credits==0 holds mem_req_valid low with the address stable.
  - mem_req_addr must not change while mem_req_valid && !mem_req_ready.
- Response FIFO, DEPTH entries:
  - Written on every mem_rsp_valid; credits guarantee it never overflows.
  - Read on out_valid && out_ready.
  - out_valid = FIFO not empty; out_texel = head entry.
  - Simultaneous write and read when full or empty must be handled, including write-to-empty and read in the same cycle (fall-through not required).
- Latency:
  - Input handshake at cycle N gives mem_req_valid at N+1.
  - mem_rsp_valid at cycle M gives out_valid at M+1.
- Ordering: texels leave in exact input order.
- Asserting mem_rsp_valid with no outstanding request is illegal. The bench flags it; the RTL behaviour is undefined.

Test Plan:
- Single fetch: base=0x1000, width_exp=4, height_exp=4, u=3, v=2 → mem_req_addr=0x1000+((2*16+3)*4)=0x108C at N+1; response 0xDEADBEEF → out_texel=0xDEADBEEF one cycle later.
- Wrap: width_exp=3, height_exp=2, u=0xFFFF, v=5, base=0 → u_w=7, v_w=1, addr=(8+7)*4=0x3C.
- Back-to-back streaming, DEPTH=4: 8 consecutive inputs, mem_req_ready=1, response latency 3, out_ready=1 → one request per cycle, 8 texels out in order, in_ready never drops.
- Credit stall: out_ready=0, 6 inputs, immediate responses → exactly 4 requests issued; mem_req_valid stays low with addr stable, in_ready low after 5 accepted; raising out_ready drains and resumes.
- Memory backpressure: mem_req_ready=0 for 5 cycles → mem_req_addr stable, in_ready=0, no lost or duplicated requests.
- Reset mid-operation: rst_n low with 2 requests outstanding and 1 texel buffered → all outputs 0 immediately, credits=DEPTH, and a subsequent single fetch behaves as in scenario 1.
